mtimer_wb: RTL and testbench
============================

Name: mtimer_wb

Overview:
Memory-mapped machine timer. Holds 64-bit mtime and mtimecmp behind a Wishbone classic slave port. Sits directly upstream of the CSR register file and drives its time_int and clear_mip inputs. Software re-arms or acknowledges the timer interrupt by writing mtimecmp.

Parameters:
BASE_MTIME, 32'h0200_BFF8, byte address of mtime[31:0]; mtime[63:32] is at +4
BASE_MTIMECMP, 32'h0200_4000, byte address of mtimecmp[31:0]; mtimecmp[63:32] is at +4
TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  1 = write
wb_adr_i  in  32  byte address; bits [1:0] ignored
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte lane enables
wb_dat_o  out  32  read data
wb_ack_o  out  1  transfer acknowledge
time_int  out  1  level; 1 while mtime >= mtimecmp (unsigned 64-bit compare)
clear_mip  out  1  one-cycle pulse when mtimecmp (either half) is written

Behaviour:
- Reset values:
  - mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; prescaler = 0.
  - wb_ack_o = 0; wb_dat_o = 0; clear_mip = 0; FSM = IDLE.
  - time_int therefore reads 0 the first cycle after reset.
- Prescaler: counts 0..TICK_DIV-1. On reaching TICK_DIV-1 it returns to 0 and mtime increments by 1. mtime wraps from 2^64-1 to 0. With TICK_DIV=1, mtime increments every cycle.
- Bus FSM, two states:
  - IDLE: if wb_cyc_i & wb_stb_i, then on this edge:
    - perform any write;
    - register wb_dat_o with the pre-write value of the addressed word;
    - wb_ack_o <= 1; go to ACK.
  - ACK: wb_ack_o <= 0; wb_dat_o held; go to IDLE.
  - Result: latency 1 cycle, ack high for exactly 1 cycle, back-to-back transfers every 2 cycles.
  - A strobe seen in ACK is not sampled.
- Address decode compares wb_adr_i[31:2] against the four word addresses.
  - Unmapped address: read returns 0, write has no effect, ack still given.
- Writes:
  - Honour wb_sel_i per byte lane; lanes with sel=0 keep their old value.
  - A write to either mtime half overrides that cycle's increment for the whole 64-bit mtime: the written half takes the new bytes, the other half holds. The prescaler is not reset.
  - No carry is performed between halves on a write.
- clear_mip: registered. Asserted 1 cycle in the same edge as ack when a mtimecmp half is written with wb_sel_i != 0; otherwise 0.
  - The CSR block gives clear priority over set. If time_int is still 1 afterwards, mip is set again on the next cycle.
- time_int is combinational from registered mtime and mtimecmp.
- Reset mid-transfer: FSM returns to IDLE and ack drops next cycle. The pending write is discarded if rst coincides with the sampling edge. The master must re-issue the transfer.

Test Plan:
- Reset, TICK_DIV=1, idle 10 cycles -> read mtime lo returns 9 or 10 (pre-read value), hi returns 0; time_int=0 throughout; ack is a single-cycle pulse 1 cycle after stb.
- Write mtimecmp hi=0, then lo=20, sel=4'hF -> clear_mip pulses once per write; time_int rises on the first cycle mtime=20 and stays 1.
- With time_int=1, write mtimecmp lo=32'hFFFF_FFFF, sel=4'hF -> clear_mip pulses, time_int falls the cycle after ack.
- Write mtime lo=32'hFFFF_FFFE, hi=0 -> after 2 further ticks mtime = 64'h1_0000_0000 (carry into hi).
- Byte-lane write: mtimecmp lo=32'h1122_3344, then write 32'hAABB_CCDD with sel=4'b0101 -> read returns 32'h11BB_33DD.
- Read 32'h1000_0000 -> ack, data 0, no state change.
- TICK_DIV=4 -> mtime increments once every 4 cycles.
- rst asserted while in ACK -> ack 0 next cycle; mtime=0 and mtimecmp=all ones.

Source files
------------

// File: rtl/mtimer_wb.sv
// Machine timer with a Wishbone classic slave port.
// Holds the 64-bit mtime counter and the 64-bit mtimecmp compare value.
// time_int is high while mtime >= mtimecmp. Writing either mtimecmp half
// produces a one-cycle clear_mip pulse, so the downstream CSR block can drop
// its pending bit.
module mtimer_wb #(
  parameter logic [31:0] BASE_MTIME    = 32'h0200_BFF8,
  parameter logic [31:0] BASE_MTIMECMP = 32'h0200_4000,
  parameter int unsigned TICK_DIV      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        time_int,
  output logic        clear_mip
);

  typedef enum logic {IDLE, ACK} state_t;

  // Word addresses of the four mapped registers. The high halves sit at +4.
  localparam logic [31:0] MTIME_HI_ADDR    = BASE_MTIME + 32'd4;
  localparam logic [31:0] MTIMECMP_HI_ADDR = BASE_MTIMECMP + 32'd4;
  localparam logic [29:0] MTIME_LO_WORD    = BASE_MTIME[31:2];
  localparam logic [29:0] MTIME_HI_WORD    = MTIME_HI_ADDR[31:2];
  localparam logic [29:0] MTIMECMP_LO_WORD = BASE_MTIMECMP[31:2];
  localparam logic [29:0] MTIMECMP_HI_WORD = MTIMECMP_HI_ADDR[31:2];

  // Last prescaler count before an mtime increment.
  localparam logic [15:0] PRE_MAX = 16'(TICK_DIV - 1);

  state_t      state_reg;
  logic [63:0] mtime_reg;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp_reg;
  logic [15:0] prescaler_reg;
  logic [15:0] prescaler_next;
  logic        tick;

  logic [29:0] word_addr;
  logic        hit_mtime_lo;
  logic        hit_mtime_hi;
  logic        hit_cmp_lo;
  logic        hit_cmp_hi;
  logic        req;
  logic        wr;
  logic [31:0] lane_mask;
  logic [31:0] rd_data;

  // A strobe is only taken in IDLE, so the ACK cycle ignores the bus.
  assign req = wb_cyc_i & wb_stb_i & (state_reg == IDLE);
  assign wr  = req & wb_we_i;

  assign word_addr    = wb_adr_i[31:2];
  assign hit_mtime_lo = (word_addr == MTIME_LO_WORD);
  assign hit_mtime_hi = (word_addr == MTIME_HI_WORD);
  assign hit_cmp_lo   = (word_addr == MTIMECMP_LO_WORD);
  assign hit_cmp_hi   = (word_addr == MTIMECMP_HI_WORD);

  // Expand each byte-lane select into an 8-bit mask for read-modify-write.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[8*gi +: 8] = {8{wb_sel_i[gi]}};
    end
  endgenerate

  // Merge the write data into an old word on the selected byte lanes only.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [31:0] mask);
    merge_word = (old_word & ~mask) | (new_word & mask);
  endfunction

  assign tick = (prescaler_reg == PRE_MAX);

  // Pre-write value of the addressed word; unmapped addresses read as zero.
  always_comb begin
    rd_data = 32'd0;
    if (hit_mtime_lo)      rd_data = mtime_reg[31:0];
    else if (hit_mtime_hi) rd_data = mtime_reg[63:32];
    else if (hit_cmp_lo)   rd_data = mtimecmp_reg[31:0];
    else if (hit_cmp_hi)   rd_data = mtimecmp_reg[63:32];
  end

  // Next mtime: a bus write to either half replaces this cycle's increment.
  always_comb begin
    prescaler_next = tick ? 16'd0 : prescaler_reg + 16'd1;
    mtime_next     = tick ? mtime_reg + 64'd1 : mtime_reg;
    if (wr && hit_mtime_lo) begin
      mtime_next = {mtime_reg[63:32], merge_word(mtime_reg[31:0], wb_dat_i, lane_mask)};
    end else if (wr && hit_mtime_hi) begin
      mtime_next = {merge_word(mtime_reg[63:32], wb_dat_i, lane_mask), mtime_reg[31:0]};
    end
  end

  // Free-running prescaler and mtime counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_reg <= 16'd0;
      mtime_reg     <= 64'd0;
    end else begin
      prescaler_reg <= prescaler_next;
      mtime_reg     <= mtime_next;
    end
  end

  // Bus FSM: accept in IDLE, acknowledge for one cycle, then return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= 32'd0;
      clear_mip    <= 1'b0;
      mtimecmp_reg <= '1;
    end else begin
      clear_mip <= 1'b0;
      case (state_reg)
        IDLE: begin
          wb_ack_o <= 1'b0;
          if (req) begin
            wb_dat_o  <= rd_data;
            wb_ack_o  <= 1'b1;
            state_reg <= ACK;
            if (wb_we_i && hit_cmp_lo) begin
              mtimecmp_reg[31:0] <= merge_word(mtimecmp_reg[31:0], wb_dat_i, lane_mask);
              clear_mip          <= (wb_sel_i != 4'd0);
            end else if (wb_we_i && hit_cmp_hi) begin
              mtimecmp_reg[63:32] <= merge_word(mtimecmp_reg[63:32], wb_dat_i, lane_mask);
              clear_mip           <= (wb_sel_i != 4'd0);
            end
          end
        end
        ACK: begin
          wb_ack_o  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          wb_ack_o  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign time_int = (mtime_reg >= mtimecmp_reg);

endmodule

// File: tb/tb_mtimer_wb.sv
// Bench for mtimer_wb: two instances (TICK_DIV=1 and TICK_DIV=4) share one
// Wishbone master. A cycle-level model tracks both timers and is compared on
// every cycle; directed transactions add literal expectations.
module tb_mtimer_wb;

  localparam logic [31:0] A_TLO = 32'h0200_BFF8;
  localparam logic [31:0] A_THI = 32'h0200_BFFC;
  localparam logic [31:0] A_CLO = 32'h0200_4000;
  localparam logic [31:0] A_CHI = 32'h0200_4004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat = '0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] dat_o, dat4_o;
  logic        ack_o, ack4_o, tint, tint4, clr, clr4;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mtimer_wb dut (
    .clk(clk), .rst(rst), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
    .wb_dat_o(dat_o), .wb_ack_o(ack_o), .time_int(tint), .clear_mip(clr)
  );

  mtimer_wb #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
    .wb_dat_o(dat4_o), .wb_ack_o(ack4_o), .time_int(tint4), .clear_mip(clr4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_time, m_time4, m_cmp;
  int          m_pre4;
  bit          m_busy;
  logic        e_ack, e_clr;
  logic [31:0] e_dat, e_dat4;

  function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] read_word(input logic [31:0] a, input logic [63:0] t,
                                            input logic [63:0] c);
    if (a[31:2] == A_TLO[31:2]) return t[31:0];
    if (a[31:2] == A_THI[31:2]) return t[63:32];
    if (a[31:2] == A_CLO[31:2]) return c[31:0];
    if (a[31:2] == A_CHI[31:2]) return c[63:32];
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    logic [63:0] nt, nt4;
    bit req;
    if (rst) begin
      m_time = 0; m_time4 = 0; m_pre4 = 0; m_cmp = '1; m_busy = 0;
      e_ack = 0; e_clr = 0; e_dat = 0; e_dat4 = 0;
    end else begin
      req = wb_cyc && wb_stb && !m_busy;
      nt = m_time + 1;
      if (m_pre4 == 3) begin nt4 = m_time4 + 1; m_pre4 = 0; end
      else begin nt4 = m_time4; m_pre4++; end
      e_clr = 0;
      if (req) begin
        e_dat  = read_word(wb_adr, m_time, m_cmp);
        e_dat4 = read_word(wb_adr, m_time4, m_cmp);
        if (wb_we) begin
          if (wb_adr[31:2] == A_TLO[31:2]) begin
            nt  = {m_time[63:32],  bytes_merge(m_time[31:0],  wb_dat, wb_sel)};
            nt4 = {m_time4[63:32], bytes_merge(m_time4[31:0], wb_dat, wb_sel)};
          end else if (wb_adr[31:2] == A_THI[31:2]) begin
            nt  = {bytes_merge(m_time[63:32],  wb_dat, wb_sel), m_time[31:0]};
            nt4 = {bytes_merge(m_time4[63:32], wb_dat, wb_sel), m_time4[31:0]};
          end else if (wb_adr[31:2] == A_CLO[31:2]) begin
            m_cmp[31:0] = bytes_merge(m_cmp[31:0], wb_dat, wb_sel);
            e_clr = (wb_sel != 0);
          end else if (wb_adr[31:2] == A_CHI[31:2]) begin
            m_cmp[63:32] = bytes_merge(m_cmp[63:32], wb_dat, wb_sel);
            e_clr = (wb_sel != 0);
          end
        end
      end
      m_time = nt; m_time4 = nt4; e_ack = req; m_busy = req;
    end
  end

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack",       ack_o,  e_ack);
      chk("ack4",      ack4_o, e_ack);
      chk("dat",       dat_o,  e_dat);
      chk("dat4",      dat4_o, e_dat4);
      chk("clear_mip", clr,    e_clr);
      chk("clear_mip4", clr4,  e_clr);
      chk("time_int",  tint,   m_time >= m_cmp);
      chk("time_int4", tint4,  m_time4 >= m_cmp);
    end
  end

  // One Wishbone transfer, called and returning on a negedge (2 cycles total).
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] d,
                     input logic [3:0] sel, output logic [31:0] rd, output logic [31:0] rd4,
                     output logic c);
    int lat;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat = d; wb_sel = sel;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack_o && lat < 8);
    chk("ack_latency", lat, 1);
    rd = dat_o; rd4 = dat4_o; c = clr;
    wb_cyc = 0; wb_stb = 0; wb_we = 0;
    @(negedge clk);
    chk("ack_single", ack_o, 0);
    $display("txn we=%0d adr=%h wdat=%h sel=%h -> rdat=%h rdat4=%h clear_mip=%0d",
             we, adr, d, sel, rd, rd4, c);
  endtask

  initial begin
    logic [31:0] r, r4, a4;
    logic c;

    // Reset and idle check
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_ack", ack_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_tint", tint, 0);
    rst = 0;
    repeat (10) @(negedge clk);
    bus(0, A_TLO, 0, 4'hF, r, r4, c);
    chk("mtime_lo_after_10", (r == 9 || r == 10), 1);
    chk("mtime4_lo_after_10", r4, 2);
    bus(0, A_THI, 0, 4'hF, r, r4, c);
    chk("mtime_hi", r, 0);

    // Arm the compare at 20
    bus(1, A_TLO, 0, 4'hF, r, r4, c);
    chk("clr_on_mtime_write", c, 0);
    bus(1, A_CHI, 0, 4'hF, r, r4, c);
    chk("clr_cmp_hi", c, 1);
    bus(1, A_CLO, 20, 4'hF, r, r4, c);
    chk("clr_cmp_lo", c, 1);
    chk("tint_before_20", tint, 0);
    for (int i = 0; i < 60 && !tint; i++) @(negedge clk);
    chk("tint_rose", tint, 1);
    bus(0, A_TLO, 0, 4'hF, r, r4, c);
    chk("mtime_at_rise", r, 20);
    chk("tint_stays", tint, 1);

    // Acknowledge by pushing mtimecmp away
    bus(1, A_CLO, 32'hFFFF_FFFF, 4'hF, r, r4, c);
    chk("clr_ack", c, 1);
    chk("tint_fell", tint, 0);

    // Carry from lo into hi
    bus(1, A_THI, 0, 4'hF, r, r4, c);
    bus(1, A_TLO, 32'hFFFF_FFFE, 4'hF, r, r4, c);
    @(negedge clk);
    bus(0, A_THI, 0, 4'hF, r, r4, c);
    chk("carry_hi", r, 1);
    bus(0, A_TLO, 0, 4'hF, r, r4, c);
    chk("carry_lo", r, 2);

    // Byte-lane write into mtimecmp lo
    bus(1, A_CLO, 32'h1122_3344, 4'hF, r, r4, c);
    bus(1, A_CLO, 32'hAABB_CCDD, 4'b0101, r, r4, c);
    chk("clr_partial", c, 1);
    bus(0, A_CLO, 0, 4'hF, r, r4, c);
    chk("byte_lanes", r, 32'h11BB_33DD);

    // Unmapped accesses
    bus(0, 32'h1000_0000, 0, 4'hF, r, r4, c);
    chk("unmapped_rd", r, 0);
    bus(1, 32'h1000_0000, 32'hDEAD_BEEF, 4'hF, r, r4, c);
    chk("unmapped_wr_clr", c, 0);
    bus(0, A_CLO, 0, 4'hF, r, r4, c);
    chk("unmapped_no_effect", r, 32'h11BB_33DD);

    // TICK_DIV=4: 8 cycles between sampling edges -> exactly 2 increments
    bus(0, A_TLO, 0, 4'hF, r, r4, c);
    a4 = r4;
    repeat (6) @(negedge clk);
    bus(0, A_TLO, 0, 4'hF, r, r4, c);
    chk("tick_div4_delta", r4 - a4, 2);

    // Reset while in ACK
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = A_TLO; wb_dat = 5; wb_sel = 4'hF;
    @(negedge clk);
    chk("ack_before_rst", ack_o, 1);
    rst = 1; wb_cyc = 0; wb_stb = 0; wb_we = 0;
    @(negedge clk);
    chk("ack_after_rst", ack_o, 0);
    rst = 0;
    bus(0, A_TLO, 0, 4'hF, r, r4, c);
    chk("rst_mtime_lo", r, 0);
    bus(0, A_THI, 0, 4'hF, r, r4, c);
    chk("rst_mtime_hi", r, 0);
    bus(0, A_CLO, 0, 4'hF, r, r4, c);
    chk("rst_cmp_lo", r, 32'hFFFF_FFFF);
    bus(0, A_CHI, 0, 4'hF, r, r4, c);
    chk("rst_cmp_hi", r, 32'hFFFF_FFFF);

    repeat (3) @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
